load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer for the data-memory side of the core's load and store instructions: LB, LHB and STR. It runs a request/acknowledge handshake with data memory and stalls the core while a transfer is in flight. For loads, it registers the returned byte as the `mem_i` source of the register writeback mux. It sits between the decode/execute stage, which supplies the opcode, address and store data, and the data memory.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum REQ-state cycles without `mem_ack` before the transfer is aborted. Legal range 1–255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe from the core, sampled in IDLE only.
- `opcode`  in  4  instruction opcode. LB = 4'b0000, LHB = 4'b0001, STR = 4'b0011. All other values are not memory ops.
- `addr_i`  in  8  data memory address.
- `wdata_i`  in  8  store data (STR only).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr`  out  8  registered address.
- `mem_wdata`  out  8  registered store data.
- `mem_rdata`  in  8  read data, valid in the cycle `mem_ack` = 1.
- `mem_ack`  in  1  memory completion.
- `mem_o`  out  8  load result to the writeback mux.
- `busy`  out  1  core stall, high in REQ and DONE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle timeout pulse, coincident with `done`.

## Operation
- States: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE:
  - `start` = 1 with opcode LB, LHB or STR → go to REQ.
  - On that transition, capture `addr_i` → `mem_addr`, `wdata_i` → `mem_wdata` (STR only; otherwise `mem_wdata` holds), op type, and `mem_we` = (opcode == STR).
  - Clear the wait counter.
  - `start` with any other opcode → stay in IDLE, no outputs change.
- REQ:
  - `mem_req` = 1, and `mem_addr`, `mem_we`, `mem_wdata` are held stable.
  - `mem_ack` = 1 → go to DONE.
    - LB: `mem_o` ← `mem_rdata`.
    - LHB: `mem_o` ← {4'h0, `mem_rdata[3:0]`}.
    - STR: `mem_o` unchanged.
  - `mem_ack` = 0 → wait counter +1. When the counter reaches `TIMEOUT` → go to DONE with the abort flag set.
    - LB/LHB abort: `mem_o` ← 8'h00.
    - STR abort: `mem_o` unchanged.
- DONE:
  - `done` = 1 for exactly one cycle; `err` = 1 that cycle if aborted.
  - `mem_req` = 0.
  - Unconditionally return to IDLE.
- `mem_o` holds its value until the next completed or aborted load.
- `start` outside IDLE is ignored. The core holds it only while `busy` = 0.
- `mem_ack` outside REQ is ignored. `mem_rdata` is ignored except in the ack cycle of a load.
- `mem_ack` in the same cycle the counter would reach `TIMEOUT`: the ack wins, with no error.
- Wait counter width is 8 bits. It saturates and never wraps.

## Timing
- Reset (asynchronous, immediate): `mem_req`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `mem_o` = 8'h00; state = IDLE; counter = 0.
- Reset asserted mid-transfer: `mem_req` drops in the same instant and the transfer is abandoned, with no `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Zero-wait transfer timing:
  - Cycle 0: `start` sampled.
  - Cycle 1: `mem_req` = 1 and `busy` = 1; `mem_ack` arrives.
  - Cycle 2: `done` = 1 and `mem_o` valid.
  - Cycle 3: IDLE, `busy` = 0.
- Each cycle of memory wait adds one cycle.
- Timeout: `mem_req` stays high for exactly `TIMEOUT` cycles, then DONE with `err`.
- Back-to-back: the next `start` is accepted at the earliest in the first cycle after DONE.
- The writeback mux may sample `mem_o` in the `done` cycle.

## Test plan
- LB, zero wait:
  - Stimulus: `addr_i` = 8'h3C, `mem_rdata` = 8'hA5, ack in the first REQ cycle.
  - Response: `mem_req` high for 1 cycle with `mem_we` = 0 and `mem_addr` = 8'h3C; `done` 2 cycles after `start`; `mem_o` = 8'hA5; `err` = 0.
- LHB, 3 wait cycles:
  - Stimulus: `mem_rdata` = 8'hB7 in the ack cycle.
  - Response: `mem_req` high for 4 cycles; `mem_o` = 8'h07.
- STR:
  - Stimulus: `addr_i` = 8'h10, `wdata_i` = 8'h5A, with `mem_o` previously 8'h07.
  - Response: `mem_we` = 1, `mem_wdata` = 8'h5A, `mem_addr` = 8'h10 held through REQ; `done` pulses; `mem_o` stays 8'h07.
- Timeout with `TIMEOUT` = 15 and no ack:
  - Response: `mem_req` high for exactly 15 cycles, then `done` = 1 and `err` = 1 for one cycle; `mem_o` = 8'h00.
  - Ack in the 15th REQ cycle: `done` with `err` = 0 and data captured.
- Ignored inputs:
  - `start` with opcode ADD (4'b0111) in IDLE → no request, `busy` stays 0.
  - `start` asserted during REQ → no second request.
  - `mem_ack` pulse in IDLE → no `done`.
- Reset mid-REQ:
  - Stimulus: `reset_n` low in the second wait cycle of a load.
  - Response: `mem_req` and `busy` drop at once, `mem_o` = 8'h00, no `done`.
  - After release, a new LB completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory sequencer for LB, LHB and STR.
// Drives the req/ack handshake, stalls the core and registers load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] mem_o,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LHB = 4'b0001;
    localparam logic [3:0] OP_STR = 4'b0011;

    // Last wait count before the abort; REQ lasts TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_lhb;
    logic       is_mem_op;

    always_comb begin
        is_mem_op = 1'b0;
        unique case (1'b1)
            (opcode == OP_LB):  is_mem_op = 1'b1;
            (opcode == OP_LHB): is_mem_op = 1'b1;
            (opcode == OP_STR): is_mem_op = 1'b1;
            default:            is_mem_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'h00;
            is_lhb    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            mem_o     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && is_mem_op) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= addr_i;
                        mem_we   <= (opcode == OP_STR);
                        is_lhb   <= (opcode == OP_LHB);
                        wait_cnt <= 8'h00;
                        if (opcode == OP_STR) begin
                            mem_wdata <= wdata_i;
                        end
                    end
                end
                S_REQ: begin
                    // Ack beats a timeout landing in the same cycle.
                    if (mem_ack) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            mem_o <= is_lhb ? {4'h0, mem_rdata[3:0]}
                                            : mem_rdata;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        if (!mem_we) begin
                            mem_o <= 8'h00;
                        end
                    end
                    if (!mem_ack && wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed transfers,
// timeout, ignored inputs and mid-transfer reset.
module tb_load_store_unit;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] opcode;
    logic [7:0] addr_i;
    logic [7:0] wdata_i;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] mem_o;
    logic       busy;
    logic       done;
    logic       err;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LHB = 4'b0001;
    localparam logic [3:0] OP_STR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0111;

    typedef struct packed {
        logic [7:0] o;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_o     (mem_o),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected completion.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mem_o !== e.o || err !== e.e) begin
                    n_bad++;
                    $display("FAIL done_resp: got mem_o=%0h err=%0b expected mem_o=%0h err=%0b",
                             mem_o, err, e.o, e.e);
                end
            end
        end
    end

    // One transfer: ack on REQ cycle waits+1 if ack_en, else no ack.
    task automatic xfer(input string name, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] wd,
                        input int waits, input logic [7:0] rd,
                        input logic ack_en, input logic hold_start,
                        input int exp_req);
        int n;
        @(negedge clk);
        start   = 1'b1;
        opcode  = op;
        addr_i  = a;
        wdata_i = wd;
        @(negedge clk);
        start   = hold_start;
        addr_i  = 8'hFF;
        wdata_i = 8'hFF;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req !== 1'b1) break;
            n++;
            if (n == 1 || mem_ack) begin
                chk({name, "_addr"}, 32'(mem_addr), 32'(a));
                chk({name, "_we"}, 32'(mem_we), 32'(op == OP_STR));
                if (op == OP_STR)
                    chk({name, "_wdata"}, 32'(mem_wdata), 32'(wd));
            end
            mem_ack   = ack_en && (n == waits + 1);
            mem_rdata = mem_ack ? rd : 8'hEE;
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        start     = 1'b0;
        chk({name, "_req_cycles"}, 32'(n), 32'(exp_req));
        chk({name, "_done_time"}, 32'(done), 32'd1);
        chk({name, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = OP_LB;
        addr_i    = 8'h00;
        wdata_i   = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_o", 32'(mem_o), 32'd0);
        reset_n = 1'b1;

        exp_q.push_back('{o: 8'hA5, e: 1'b0});
        xfer("lb0", OP_LB, 8'h3C, 8'h00, 0, 8'hA5, 1'b1, 1'b0, 1);

        exp_q.push_back('{o: 8'h07, e: 1'b0});
        xfer("lhb3", OP_LHB, 8'h20, 8'h00, 3, 8'hB7, 1'b1, 1'b0, 4);

        exp_q.push_back('{o: 8'h07, e: 1'b0});
        xfer("str", OP_STR, 8'h10, 8'h5A, 1, 8'h99, 1'b1, 1'b0, 2);
        chk("str_mem_o_kept", 32'(mem_o), 32'h07);

        exp_q.push_back('{o: 8'h00, e: 1'b1});
        xfer("lb_to", OP_LB, 8'h44, 8'h00, 0, 8'h00, 1'b0, 1'b0, 15);

        exp_q.push_back('{o: 8'h3C, e: 1'b0});
        xfer("lb_ack15", OP_LB, 8'h45, 8'h00, 14, 8'h3C, 1'b1, 1'b0, 15);

        exp_q.push_back('{o: 8'h3C, e: 1'b1});
        xfer("str_to", OP_STR, 8'h46, 8'h81, 0, 8'h00, 1'b0, 1'b0, 15);

        // Non-memory opcode is ignored.
        @(negedge clk);
        start  = 1'b1;
        opcode = OP_ADD;
        @(negedge clk);
        start  = 1'b0;
        opcode = OP_LB;
        for (int i = 0; i < 3; i++) begin
            chk("add_req", 32'(mem_req), 32'd0);
            chk("add_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // start held through REQ must not spawn a second request.
        exp_q.push_back('{o: 8'h6E, e: 1'b0});
        xfer("lb_hold", OP_LB, 8'h21, 8'h00, 2, 8'h6E, 1'b1, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            chk("hold_no_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end

        // Stray ack in IDLE.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_ack_done2", 32'(done), 32'd0);

        // Reset in the second wait cycle of a load.
        start  = 1'b1;
        opcode = OP_LB;
        addr_i = 8'h77;
        @(negedge clk);
        start = 1'b0;
        chk("rstmid_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("rstmid_req2", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_req_drop", 32'(mem_req), 32'd0);
        chk("rstmid_busy_drop", 32'(busy), 32'd0);
        chk("rstmid_mem_o", 32'(mem_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_no_done", 32'(done), 32'd0);

        exp_q.push_back('{o: 8'hC3, e: 1'b0});
        xfer("lb_post", OP_LB, 8'h55, 8'h00, 0, 8'hC3, 1'b1, 1'b0, 1);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
